fix_parser_top: RTL and testbench
=================================

// Module: fix_parser_top
// PURPOSE
// - Streaming FIX byte-parser with a message store. Splits an incoming FIX stream into tag=value fields,
//   verifies each message's tag-10 checksum and keeps parsed fields per message.
// - Host looks up one field at a time by (message number, tag). Sits between a byte source and host logic.
// PARAMETERS
// - MSG_DEPTH      4   messages stored after reset (storage is not freed; only reset clears it)
// - FIELDS_PER_MSG 16  fields stored per message; further fields are parsed but not stored
// PORTS
// - clk                   in   1    single clock, rising edge
// - rst                   in   1    asynchronous, active-low reset
// - data_i                in   8    stream byte, consumed every clock while rst is high (no strobe)
// - find_tag_i            in   32   lookup tag, ASCII digits right-aligned ("10"=32'h3130, "9"=32'h39)
// - message_num_i         in   10   lookup message index (0 = first message completed after reset)
// - read_message_i        in   1    lookup request, sampled each clock
// - output_value_o        out  256  looked-up value, ASCII right-aligned
// - output_value_valid_o  out  1    lookup hit, 1-cycle pulse
// - start_of_header_o     out  1    1-cycle pulse: new message started
// - empty_o               out  1    no message stored
// - full_o                out  1    MSG_DEPTH messages stored
// - checksum_valid_o      out  1    checksum result of the last completed message
// BEHAVIOUR
// - Reset: every output 0 except empty_o=1. Message count, parser and checksum state cleared.
// - Byte classes: SOH=8'h01 ends a field; '='=8'h3D ends a tag.
// - FSM states: HUNT, TAG, VALUE.
//   - HUNT: waits for a field whose tag is "8"; bytes before that are ignored.
//   - TAG: shifts bytes in as tag = {tag[23:0], byte}; only the last 4 are kept. '=' -> VALUE.
//   - VALUE: shifts bytes in as value = {value[247:0], byte}; only the last 32 are kept.
//     SOH completes the field -> TAG, with tag and value cleared.
// - Tag "8" recognised (its '=' seen) starts a new message:
//   - start_of_header_o pulses in the next cycle; field counter and checksum sum restart.
//   - The sum includes the '8' and '=' bytes.
// - Checksum sum: mod-256 sum of every byte from the '8' of "8=" through the SOH preceding "10=".
//   - The sum is snapshotted at each SOH; the snapshot taken when tag 3130 is recognised is used.
// - Completed field (SOH) with field count < FIELDS_PER_MSG and store not full:
//   - (tag, value) is written to slot[count][field]; the tag-10 field is stored too.
// - Tag-10 field SOH ends the message:
//   - checksum_valid_o is registered the next cycle and held until the next message ends.
//   - It is 1 iff the value is exactly 3 ASCII digits whose decimal value equals the snapshot.
//   - Any non-digit -> 0.
//   - If not full, the message count increments; empty_o/full_o are updated the same cycle.
//   - Next state is HUNT.
// - Full store: new messages are still parsed and checksummed, but not stored and not counted.
// - Lookup: request registered; result appears the cycle after read_message_i is sampled high.
//   - Hit requires message_num_i < count and a stored field whose tag equals find_tag_i.
//   - If several fields match, the lowest field index wins.
//   - Hit: output_value_o = value, output_value_valid_o = 1.
//   - Miss: output_value_o = 0, output_value_valid_o = 0.
//   - Back-to-back requests are allowed: one result per cycle, independent of concurrent parsing.
//   - A message still being received is not visible.
// - output_value_o holds its value until the next request; output_value_valid_o is 0 on cycles with no request.
// - Reset mid-message: the partial message is discarded; count returns to 0.
// STRUCTURE
// - Package fix_parser_pkg:
//   - constants SOH, EQ, TAG_BEGIN=32'h38, TAG_CHECKSUM=32'h3130
//   - widths TAG_W=32, VAL_W=256, MSGNUM_W=10
//   - FSM state enum
// - Sub-module fix_field_store: tag/value memory, message count, empty/full, parallel tag compare for lookup.
// - Top module holds the parser FSM, the checksum logic and the pulse outputs.
// TESTING
// - Stream SOH,"8=FIX.4.2|9=178|35=8|49=PHLX|52=20071123-05:30:00.000|11=ATOMNOCCC9990900|10=098|" (|=SOH):
//   -> one start_of_header_o pulse; checksum_valid_o=1; empty_o=0.
// - Lookup message 0, tag 32'h3130 -> next cycle valid=1, value=24'h303938.
//   Next request tag 32'h39 -> value=24'h313738.
//   Tag 32'h3131 -> value="ATOMNOCCC9990900" right-aligned.
// - Same message with the 10 value bytes 87 65 45 -> checksum_valid_o=0 while message 0 lookups keep working.
//   Then message 1, tag 3130 -> 24'h876545.
// - Misses: message 2 while only 2 stored, tag 32'h3939, request during parsing -> valid=0, value=0.
// - Five messages -> full_o=1 after the 4th. The 5th is not stored; lookup of message 4 misses; checksum still reported.
// - Assert rst low mid-message -> all outputs at reset values, empty_o=1.
//   A fresh message afterwards is stored as message 0.

Source files
------------

// File: rtl/fix_parser_pkg.sv
// Shared constants, types and checksum helper for the FIX byte parser.
package fix_parser_pkg;
  localparam int TAG_W    = 32;
  localparam int VAL_W    = 256;
  localparam int MSGNUM_W = 10;

  localparam logic [7:0]       SOH          = 8'h01;
  localparam logic [7:0]       EQ           = 8'h3D;
  localparam logic [TAG_W-1:0] TAG_BEGIN    = 32'h38;
  localparam logic [TAG_W-1:0] TAG_CHECKSUM = 32'h3130;

  typedef enum logic [1:0] {HUNT, TAG, VALUE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] value;
  } field_t;

  function automatic logic is_digit(logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // True only for exactly three ASCII digits spelling sum in decimal.
  function automatic logic checksum_ok(logic [VAL_W-1:0] v, logic [7:0] sum);
    logic [9:0] dec;
    if (v[VAL_W-1:24] != '0) return 1'b0;
    if (!(is_digit(v[23:16]) && is_digit(v[15:8]) && is_digit(v[7:0]))) return 1'b0;
    dec = 10'(v[23:16] - 8'h30) * 10'd100 + 10'(v[15:8] - 8'h30) * 10'd10
        + 10'(v[7:0] - 8'h30);
    return dec == {2'b00, sum};
  endfunction
endpackage

// File: rtl/fix_field_store.sv
// Per-message field memory with message count and registered parallel tag lookup.
module fix_field_store
  import fix_parser_pkg::*;
#(
  parameter int MSG_DEPTH      = 4,
  parameter int FIELDS_PER_MSG = 16,
  localparam int FIDX_W        = $clog2(FIELDS_PER_MSG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_slot,
  input  logic                wr_en,
  input  logic [FIDX_W-1:0]   wr_field,
  input  field_t              wr_data,
  input  logic                commit,
  input  logic                rd_en,
  input  logic [MSGNUM_W-1:0] rd_msg,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic [VAL_W-1:0]    rd_value,
  output logic                rd_valid,
  output logic                empty,
  output logic                full
);
  localparam int MIDX_W = $clog2(MSG_DEPTH);
  localparam int CNT_W  = $clog2(MSG_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MSG_DEPTH);

  field_t                                     mem [MSG_DEPTH][FIELDS_PER_MSG];
  logic [MSG_DEPTH-1:0][FIELDS_PER_MSG-1:0]   vld;
  logic [CNT_W-1:0]                           cnt;
  logic [MIDX_W-1:0]                          wslot, rslot;
  logic                                       in_range, hit;
  logic [FIELDS_PER_MSG-1:0]                  match;
  logic [VAL_W-1:0]                           hit_val;

  assign wslot    = cnt[MIDX_W-1:0];
  assign rslot    = rd_msg[MIDX_W-1:0];
  assign full     = (cnt == DEPTH_C);
  assign empty    = (cnt == '0);
  assign in_range = (rd_msg < MSGNUM_W'(cnt));

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      vld <= '0;
    end else if (!full) begin
      // a new message reuses the slot an abandoned partial may have filled
      if (clr_slot) vld[wslot] <= '0;
      if (wr_en)    vld[wslot][wr_field] <= 1'b1;
      if (commit)   cnt <= cnt + CNT_W'(1);
    end

  always_ff @(posedge clk)
    if (wr_en && !full) mem[wslot][wr_field] <= wr_data;

  for (genvar f = 0; f < FIELDS_PER_MSG; f++) begin : g_cmp
    assign match[f] = vld[rslot][f] && (mem[rslot][f].tag == rd_tag);
  end

  // walk from the top so the lowest matching field index wins
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int f = FIELDS_PER_MSG - 1; f >= 0; f--)
      if (in_range && match[f]) begin
        hit     = 1'b1;
        hit_val = mem[rslot][f].value;
      end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_value <= '0;
    end else if (rd_en) begin
      rd_valid <= hit;
      rd_value <= hit_val;
    end else begin
      rd_valid <= 1'b0;
    end
endmodule

// File: rtl/fix_parser_top.sv
// FIX stream parser: splits tag=value fields, checks tag-10 checksum, stores fields.
module fix_parser_top
  import fix_parser_pkg::*;
#(
  parameter int MSG_DEPTH      = 4,
  parameter int FIELDS_PER_MSG = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          data_i,
  input  logic [TAG_W-1:0]    find_tag_i,
  input  logic [MSGNUM_W-1:0] message_num_i,
  input  logic                read_message_i,
  output logic [VAL_W-1:0]    output_value_o,
  output logic                output_value_valid_o,
  output logic                start_of_header_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                checksum_valid_o
);
  localparam int FIDX_W = $clog2(FIELDS_PER_MSG);
  localparam int FCNT_W = $clog2(FIELDS_PER_MSG + 1);
  localparam logic [FCNT_W-1:0] FMAX = FCNT_W'(FIELDS_PER_MSG);

  state_t            state, state_nxt;
  logic [TAG_W-1:0]  tag_q, tag_nxt;
  logic [VAL_W-1:0]  val_q, val_nxt;
  logic [7:0]        sum_q, sum_nxt, snap_q, snap_nxt;
  logic [FCNT_W-1:0] fcnt_q, fcnt_nxt;
  logic              msg_start, field_done, msg_end, wr_en;
  field_t            wr_data;

  always_comb begin
    state_nxt  = state;
    tag_nxt    = tag_q;
    val_nxt    = val_q;
    sum_nxt    = sum_q + data_i;
    snap_nxt   = snap_q;
    fcnt_nxt   = fcnt_q;
    msg_start  = 1'b0;
    field_done = 1'b0;
    msg_end    = 1'b0;
    case (state)
      HUNT: begin
        sum_nxt = sum_q;
        if (data_i == EQ && tag_q == TAG_BEGIN) msg_start = 1'b1;
        else if (data_i == EQ || data_i == SOH) tag_nxt = '0;
        else tag_nxt = {tag_q[TAG_W-9:0], data_i};
      end
      TAG: begin
        if (data_i == EQ && tag_q == TAG_BEGIN) msg_start = 1'b1;
        else if (data_i == EQ) state_nxt = VALUE;
        else if (data_i == SOH) tag_nxt = '0;
        else tag_nxt = {tag_q[TAG_W-9:0], data_i};
      end
      VALUE: begin
        if (data_i == SOH) begin
          field_done = 1'b1;
          state_nxt  = TAG;
          tag_nxt    = '0;
          val_nxt    = '0;
          if (fcnt_q < FMAX) fcnt_nxt = fcnt_q + FCNT_W'(1);
          // the snapshot from the SOH before "10=" is the one to compare against
          if (tag_q == TAG_CHECKSUM) begin
            msg_end   = 1'b1;
            state_nxt = HUNT;
          end else begin
            snap_nxt = sum_q + data_i;
          end
        end else begin
          val_nxt = {val_q[VAL_W-9:0], data_i};
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (msg_start) begin
      state_nxt = VALUE;
      val_nxt   = '0;
      sum_nxt   = TAG_BEGIN[7:0] + EQ;
      fcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state             <= HUNT;
      tag_q             <= '0;
      val_q             <= '0;
      sum_q             <= '0;
      snap_q            <= '0;
      fcnt_q            <= '0;
      start_of_header_o <= 1'b0;
      checksum_valid_o  <= 1'b0;
    end else begin
      state             <= state_nxt;
      tag_q             <= tag_nxt;
      val_q             <= val_nxt;
      sum_q             <= sum_nxt;
      snap_q            <= snap_nxt;
      fcnt_q            <= fcnt_nxt;
      start_of_header_o <= msg_start;
      if (msg_end) checksum_valid_o <= checksum_ok(val_q, snap_q);
    end

  assign wr_en   = field_done && (fcnt_q < FMAX);
  assign wr_data = {tag_q, val_q};

  fix_field_store #(
    .MSG_DEPTH     (MSG_DEPTH),
    .FIELDS_PER_MSG(FIELDS_PER_MSG)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .clr_slot(msg_start),
    .wr_en   (wr_en),
    .wr_field(fcnt_q[FIDX_W-1:0]),
    .wr_data (wr_data),
    .commit  (msg_end),
    .rd_en   (read_message_i),
    .rd_msg  (message_num_i),
    .rd_tag  (find_tag_i),
    .rd_value(output_value_o),
    .rd_valid(output_value_valid_o),
    .empty   (empty_o),
    .full    (full_o)
  );
endmodule

// File: tb/tb_fix_parser_top.sv
// Randomized bench for fix_parser_top against a string-level message model.
module tb_fix_parser_top;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   data = 8'h00;
  logic [31:0]  find_tag = '0;
  logic [9:0]   msg_num = '0;
  logic         rd = 1'b0;
  logic [255:0] out_val;
  logic         out_vld, sof, empty, full, ck;

  always #5 clk = ~clk;

  fix_parser_top dut (
    .clk(clk), .rst(rst), .data_i(data), .find_tag_i(find_tag),
    .message_num_i(msg_num), .read_message_i(rd),
    .output_value_o(out_val), .output_value_valid_o(out_vld),
    .start_of_header_o(sof), .empty_o(empty), .full_o(full),
    .checksum_valid_o(ck)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(string name, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // model: fields of stored messages, current message as strings
  logic [31:0]  m_tag [4][16];
  logic [255:0] m_val [4][16];
  int           m_nf [4];
  int           m_cnt = 0;
  logic [255:0] exp_out = '0;
  int           sof_seen = 0, sof_exp = 0;
  string        f_tag[$], f_val[$];

  always @(negedge clk) if (sof) sof_seen++;

  function automatic logic [255:0] s2v(string s);
    logic [255:0] r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[247:0], 8'(s[i])};
    return r;
  endfunction

  function automatic int msg_sum();
    int s = 0;
    for (int f = 0; f < f_tag.size(); f++) begin
      if (f_tag[f] == "10") break;
      for (int i = 0; i < f_tag[f].len(); i++) s += int'(8'(f_tag[f][i]));
      s += 8'h3D;
      for (int i = 0; i < f_val[f].len(); i++) s += int'(8'(f_val[f][i]));
      s += 1;
    end
    return s % 256;
  endfunction

  function automatic bit exp_ck_ok();
    string v = f_val[f_val.size() - 1];
    int d = 0;
    logic [7:0] b;
    if (v.len() != 3) return 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = 8'(v[i]);
      if (b < 8'h30 || b > 8'h39) return 1'b0;
      d = d * 10 + int'(b) - 48;
    end
    return d == msg_sum();
  endfunction

  function automatic void mdl_lookup(int num, logic [31:0] t, output bit hit,
                                     output logic [255:0] v);
    hit = 1'b0;
    v   = '0;
    if (num >= m_cnt) return;
    for (int f = 0; f < m_nf[num]; f++)
      if (m_tag[num][f] == t) begin
        hit = 1'b1;
        v   = m_val[num][f];
        return;
      end
  endfunction

  // one stream byte per clock, with a random concurrent lookup
  task automatic cycle(logic [7:0] b);
    bit req = 1'($urandom_range(0, 1));
    int num = $urandom_range(0, m_cnt + 1);
    logic [31:0] t;
    bit hit;
    logic [255:0] v;
    if (num < m_cnt && $urandom_range(0, 1) == 1)
      t = m_tag[num][$urandom_range(0, m_nf[num] - 1)];
    else
      t = 32'(s2v($sformatf("%0d", $urandom_range(8, 30))));
    mdl_lookup(num, t, hit, v);
    data = b; rd = req; msg_num = 10'(num); find_tag = t;
    @(posedge clk); #1;
    rd = 1'b0;
    if (req) begin
      exp_out = v;
      check("lookup_vld", out_vld, hit);
      check("lookup_val", out_val, v);
    end else begin
      check("idle_vld", out_vld, 0);
      check("hold_val", out_val, exp_out);
    end
  endtask

  task automatic send_msg(int abort_at);
    logic [7:0] q[$];
    int nf;
    q.push_back(8'h01);
    for (int f = 0; f < f_tag.size(); f++) begin
      for (int i = 0; i < f_tag[f].len(); i++) q.push_back(8'(f_tag[f][i]));
      q.push_back(8'h3D);
      for (int i = 0; i < f_val[f].len(); i++) q.push_back(8'(f_val[f][i]));
      q.push_back(8'h01);
    end
    for (int k = 0; k < q.size(); k++) begin
      if (abort_at >= 0 && k == abort_at) return;
      cycle(q[k]);
    end
    sof_exp++;
    if (m_cnt < 4) begin
      nf = (f_tag.size() < 16) ? f_tag.size() : 16;
      m_nf[m_cnt] = nf;
      for (int f = 0; f < nf; f++) begin
        m_tag[m_cnt][f] = 32'(s2v(f_tag[f]));
        m_val[m_cnt][f] = s2v(f_val[f]);
      end
      m_cnt++;
    end
    check("cksum", ck, exp_ck_ok());
    check("empty", empty, m_cnt == 0);
    check("full", full, m_cnt == 4);
    check("sof_cnt", sof_seen, sof_exp);
  endtask

  task automatic load_spec_msg();
    f_tag = '{"8", "9", "35", "49", "52", "11", "10"};
    f_val = '{"FIX.4.2", "178", "8", "PHLX", "20071123-05:30:00.000",
              "ATOMNOCCC9990900", "098"};
  endtask

  task automatic make_random_msg();
    int nmid = $urandom_range(1, 18);
    int s;
    string v;
    f_tag.delete(); f_val.delete();
    f_tag.push_back("8"); f_val.push_back("FIX.4.4");
    for (int i = 0; i < nmid; i++) begin
      f_tag.push_back($sformatf("%0d", $urandom_range(11, 29)));
      v = "";
      for (int j = $urandom_range(1, 40); j > 0; j--)
        v = {v, $sformatf("%c", 8'($urandom_range(33, 126)))};
      f_val.push_back(v);
    end
    s = msg_sum();
    case ($urandom_range(0, 3))
      0, 1:    v = $sformatf("%03d", s);
      2:       v = $sformatf("%03d", (s + 1 + $urandom_range(0, 998)) % 1000);
      default: v = $sformatf("%02d", s % 100);
    endcase
    f_tag.push_back("10"); f_val.push_back(v);
  endtask

  task automatic lookup_fixed(string name, int num, logic [31:0] t, bit ehit,
                              logic [255:0] ev);
    data = 8'h00; rd = 1'b1; msg_num = 10'(num); find_tag = t;
    @(posedge clk); #1;
    rd = 1'b0;
    exp_out = ev;
    check({name, "_vld"}, out_vld, ehit);
    check({name, "_val"}, out_val, ev);
  endtask

  task automatic check_reset_state(string name);
    check({name, "_val"}, out_val, 0);
    check({name, "_vld"}, out_vld, 0);
    check({name, "_sof"}, sof, 0);
    check({name, "_empty"}, empty, 1);
    check({name, "_full"}, full, 0);
    check({name, "_ck"}, ck, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    load_spec_msg();
    send_msg(-1);
    check("spec_ck", ck, 1);
    lookup_fixed("m0_t10", 0, 32'h3130, 1'b1, 256'h303938);
    lookup_fixed("m0_t9", 0, 32'h39, 1'b1, 256'h313738);
    lookup_fixed("m0_t11", 0, 32'h3131, 1'b1, 256'h41544f4d4e4f4343433939393039303030 >> 8);

    load_spec_msg();
    f_val[6] = $sformatf("%c%c%c", 8'h87, 8'h65, 8'h45);
    send_msg(-1);
    check("bad_ck", ck, 0);
    lookup_fixed("m1_t10", 1, 32'h3130, 1'b1, 256'h876545);
    lookup_fixed("m0_again", 0, 32'h39, 1'b1, 256'h313738);
    lookup_fixed("miss_msg2", 2, 32'h39, 1'b0, 256'h0);
    lookup_fixed("miss_tag", 0, 32'h3939, 1'b0, 256'h0);

    for (int m = 2; m < 6; m++) begin
      make_random_msg();
      send_msg(-1);
      if (m == 3) check("full_at4", full, 1);
    end
    lookup_fixed("miss_msg4", 4, 32'h38, 1'b0, 256'h0);
    lookup_fixed("m3_t8", 3, 32'h38, 1'b1, s2v("FIX.4.4"));

    make_random_msg();
    send_msg(20);
    #2 rst = 1'b0;
    #1 check_reset_state("midrst");
    m_cnt = 0; exp_out = '0; sof_seen = 0; sof_exp = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    load_spec_msg();
    send_msg(-1);
    lookup_fixed("post_m0_t10", 0, 32'h3130, 1'b1, 256'h303938);
    lookup_fixed("post_miss_m1", 1, 32'h3130, 1'b0, 256'h0);
    for (int m = 0; m < 2; m++) begin
      make_random_msg();
      send_msg(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
